// File: rtl/vend_pkg.sv
// Shared definitions for the newspaper vending machine.
// Holds the coin codes consumed by the vend FSM and the coin_encoder output FSM states.
package vend_pkg;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_EMIT = 2'd1,
    ENC_GAP  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// Per-sensor input conditioning for the coin acceptor.
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous, active-low reset
//   raw     - asynchronous raw sensor line, may glitch
//   pulse_c - one-cycle coin event (combinational from registered state)
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          deb;
  logic          deb_q;

  // Level is accepted only once the counter has saturated.
  assign deb = (cnt == CW'(DEBOUNCE_CYCLES));

  // Two-flop synchronizer, saturating run counter and edge-detect history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      deb_q <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      if (!sync2) begin
        cnt <= '0;
      end else if (!deb) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Rising edge of the debounced level; the sensor must drop before re-arming.
  assign pulse_c = deb & ~deb_q;

endmodule

// File: rtl/coin_encoder.sv
// Coin-acceptor front end: debounces nickel/dime sensors, queues coin events
// and presents them to the vend FSM as one-cycle coin codes with idle gaps.
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-low reset
//   nickel_in  - raw nickel sensor (asynchronous)
//   dime_in    - raw dime sensor (asynchronous)
//   coin       - 00 none, 01 nickel, 10 dime (one-cycle pulse)
//   reject     - one-cycle pulse when a coin event is dropped
//   queue_full - FIFO occupancy equals QDEPTH
//   pending    - FIFO occupancy
module coin_encoder
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter int unsigned QDEPTH          = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             nickel_in,
  input  logic                             dime_in,
  output logic [1:0]                       coin,
  output logic                             reject,
  output logic                             queue_full,
  output logic [$clog2(QDEPTH + 1)-1:0]    pending
);

  localparam int unsigned CNTW = $clog2(QDEPTH + 1);
  localparam int unsigned PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(QDEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  logic            nickel_ev_c;
  logic            dime_ev_c;

  enc_state_e      state;
  enc_state_e      state_d;
  logic [GW-1:0]   gcnt;
  logic [GW-1:0]   gcnt_d;
  logic [1:0]      coin_d;
  logic            reject_d;
  logic            pop_c;
  logic            push_c;
  logic [1:0]      push_code_c;
  logic [CNTW-1:0] count_d;

  logic [1:0]      mem [QDEPTH];
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
    .clock   (clock),
    .reset   (reset),
    .raw     (nickel_in),
    .pulse_c (nickel_ev_c)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .clock   (clock),
    .reset   (reset),
    .raw     (dime_in),
    .pulse_c (dime_ev_c)
  );

  // Output FSM next state, event resolution and FIFO occupancy.
  always_comb begin
    state_d     = state;
    gcnt_d      = gcnt;
    coin_d      = COIN_NONE;
    pop_c       = 1'b0;
    push_c      = 1'b0;
    push_code_c = COIN_NONE;
    reject_d    = 1'b0;
    count_d     = pending;

    case (state)
      ENC_IDLE: begin
        if (pending != '0) begin
          pop_c   = 1'b1;
          coin_d  = mem[rd_ptr];
          state_d = ENC_EMIT;
        end
      end
      ENC_EMIT: begin
        state_d = ENC_GAP;
        gcnt_d  = '0;
      end
      ENC_GAP: begin
        // Last gap cycle also makes the idle decision, so codes can be
        // spaced exactly 1+GAP_CYCLES apart.
        if (gcnt == GW'(GAP_CYCLES - 1)) begin
          if (pending != '0) begin
            pop_c   = 1'b1;
            coin_d  = mem[rd_ptr];
            state_d = ENC_EMIT;
          end else begin
            state_d = ENC_IDLE;
          end
        end else begin
          gcnt_d = gcnt + GW'(1);
        end
      end
      default: state_d = ENC_IDLE;
    endcase

    // Simultaneous coins are ambiguous; a pop this cycle frees a full slot.
    if (nickel_ev_c && dime_ev_c) begin
      reject_d = 1'b1;
    end else if (nickel_ev_c || dime_ev_c) begin
      push_code_c = nickel_ev_c ? COIN_NICKEL : COIN_DIME;
      if (queue_full && !pop_c) begin
        reject_d = 1'b1;
      end else begin
        push_c = 1'b1;
      end
    end

    case ({push_c, pop_c})
      2'b10:   count_d = pending + CNTW'(1);
      2'b01:   count_d = pending - CNTW'(1);
      default: count_d = pending;
    endcase
  end

  // State, output and FIFO pointer registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ENC_IDLE;
      gcnt       <= '0;
      coin       <= COIN_NONE;
      reject     <= 1'b0;
      pending    <= '0;
      queue_full <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_d;
      gcnt       <= gcnt_d;
      coin       <= coin_d;
      reject     <= reject_d;
      pending    <= count_d;
      queue_full <= (count_d == CNTW'(QDEPTH));
      if (pop_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr] <= push_code_c;
    end
  end

endmodule

// File: tb/tb_coin_encoder.sv
// Self-checking bench for coin_encoder: instance 0 uses GAP_CYCLES=2,
// instance 1 uses GAP_CYCLES=100. A timing-level reference model predicts
// every output each cycle; scenario tasks add direct expectations.
module tb_coin_encoder;

  localparam int unsigned DEB = 4;
  localparam int unsigned QD  = 4;

  logic       clk;
  logic       rst_n;
  logic       nk     [2];
  logic       dm     [2];
  logic [1:0] coin_o [2];
  logic       rej_o  [2];
  logic       full_o [2];
  logic [2:0] pend_o [2];

  int n_checks;
  int n_fail;

  coin_encoder #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(2), .QDEPTH(QD)) dut_a (
    .clock      (clk),
    .reset      (rst_n),
    .nickel_in  (nk[0]),
    .dime_in    (dm[0]),
    .coin       (coin_o[0]),
    .reject     (rej_o[0]),
    .queue_full (full_o[0]),
    .pending    (pend_o[0])
  );

  coin_encoder #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(100), .QDEPTH(QD)) dut_b (
    .clock      (clk),
    .reset      (rst_n),
    .nickel_in  (nk[1]),
    .dime_in    (dm[1]),
    .coin       (coin_o[1]),
    .reject     (rej_o[1]),
    .queue_full (full_o[1]),
    .pending    (pend_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted coin is a run of DEB consecutive high
  // samples; it reaches the queue three edges after the sample that
  // completes the run. Pops are allowed once 1+GAP edges have passed since
  // the previous pop.
  int         run_n [2];
  int         run_d [2];
  bit [2:0]   dly_n [2];
  bit [2:0]   dly_d [2];
  logic [1:0] mq    [2][QD];
  int         qh    [2];
  int         qc    [2];
  int         next_free [2];
  int         tick;
  logic [6:0] exp_o [2];
  bit         m_ev_n, m_ev_d, m_rj;
  logic [1:0] m_pc;
  int         m_gap;

  always @(posedge clk) begin
    tick = tick + 1;
    for (int i = 0; i < 2; i++) begin
      m_gap = (i == 0) ? 2 : 100;
      if (!rst_n) begin
        run_n[i] = 0; run_d[i] = 0; dly_n[i] = '0; dly_d[i] = '0;
        qh[i] = 0; qc[i] = 0; next_free[i] = 0; exp_o[i] = '0;
      end else begin
        m_ev_n = dly_n[i][2];
        m_ev_d = dly_d[i][2];
        run_n[i] = (nk[i] === 1'b1) ? ((run_n[i] > int'(DEB)) ? run_n[i] : run_n[i] + 1) : 0;
        run_d[i] = (dm[i] === 1'b1) ? ((run_d[i] > int'(DEB)) ? run_d[i] : run_d[i] + 1) : 0;
        dly_n[i] = {dly_n[i][1:0], run_n[i] == int'(DEB)};
        dly_d[i] = {dly_d[i][1:0], run_d[i] == int'(DEB)};
        m_pc = 2'b00;
        if (qc[i] > 0 && tick >= next_free[i]) begin
          m_pc = mq[i][qh[i]];
          qh[i] = (qh[i] + 1) % QD;
          qc[i] = qc[i] - 1;
          next_free[i] = tick + 1 + m_gap;
        end
        m_rj = 1'b0;
        if (m_ev_n && m_ev_d) begin
          m_rj = 1'b1;
        end else if (m_ev_n || m_ev_d) begin
          if (qc[i] == QD) begin
            m_rj = 1'b1;
          end else begin
            mq[i][(qh[i] + qc[i]) % QD] = m_ev_n ? 2'b01 : 2'b10;
            qc[i] = qc[i] + 1;
          end
        end
        exp_o[i] = {m_pc, m_rj, qc[i] == QD, 3'(qc[i])};
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int j = 0; j < 23; j++) begin
      if (j == 3) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ({coin_o[i], rej_o[i], full_o[i], pend_o[i]} !== 7'b0) begin
          n_fail++;
          $display("FAIL reset_idle inst%0d j=%0d: got %b want 0000000", i, j,
                   {coin_o[i], rej_o[i], full_o[i], pend_o[i]});
        end
      end
    end
  endtask

  task automatic test_single_coin(input bit is_dime);
    logic [1:0] code;
    code = is_dime ? 2'b10 : 2'b01;
    if (is_dime) dm[0] = 1'b1; else nk[0] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (j == 10) begin nk[0] = 1'b0; dm[0] = 1'b0; end
      @(posedge clk); #1;
      n_checks++;
      if ({coin_o[0], rej_o[0], full_o[0], pend_o[0]} !== exp_o[0]) begin
        n_fail++;
        $display("FAIL single_model j=%0d: got %b want %b", j,
                 {coin_o[0], rej_o[0], full_o[0], pend_o[0]}, exp_o[0]);
      end
      n_checks++;
      if (coin_o[0] !== ((j == 7) ? code : 2'b00)) begin
        n_fail++;
        $display("FAIL single_latency j=%0d: coin %b want %b", j, coin_o[0],
                 (j == 7) ? code : 2'b00);
      end
    end
  endtask

  task automatic test_short_pulse();
    nk[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j == 3) nk[0] = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({coin_o[0], rej_o[0], pend_o[0]} !== 6'b0) begin
        n_fail++;
        $display("FAIL short_pulse j=%0d: got coin=%b rej=%b pend=%0d want all 0",
                 j, coin_o[0], rej_o[0], pend_o[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    nk[0] = 1'b1; dm[0] = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (j == 10) begin nk[0] = 1'b0; dm[0] = 1'b0; end
      @(posedge clk); #1;
      n_checks++;
      if ({coin_o[0], rej_o[0], pend_o[0]} !== {2'b00, (j == 6), 3'd0}) begin
        n_fail++;
        $display("FAIL simultaneous j=%0d: coin=%b rej=%b pend=%0d want coin=00 rej=%0d pend=0",
                 j, coin_o[0], rej_o[0], pend_o[0], (j == 6));
      end
    end
  endtask

  task automatic test_queue_full();
    int pulses[$];
    int rejects;
    int max_pend;
    bit saw_full;
    rejects = 0; max_pend = 0; saw_full = 1'b0;
    for (int j = 0; j < 520; j++) begin
      nk[1] = (j < 72) && ((j % 12) < 6);
      @(posedge clk); #1;
      n_checks++;
      if ({coin_o[1], rej_o[1], full_o[1], pend_o[1]} !== exp_o[1]) begin
        n_fail++;
        $display("FAIL queue_model j=%0d: got %b want %b", j,
                 {coin_o[1], rej_o[1], full_o[1], pend_o[1]}, exp_o[1]);
      end
      if (coin_o[1] == 2'b01) pulses.push_back(j);
      if (rej_o[1] === 1'b1) rejects++;
      if (int'(pend_o[1]) > max_pend) max_pend = int'(pend_o[1]);
      if (full_o[1] === 1'b1) saw_full = 1'b1;
    end
    n_checks++;
    if (pulses.size() != 5) begin
      n_fail++;
      $display("FAIL queue_pulse_count: got %0d want 5", pulses.size());
    end else begin
      for (int p = 0; p < 5; p++) begin
        n_checks++;
        if (pulses[p] != 7 + 101 * p) begin
          n_fail++;
          $display("FAIL queue_pulse_time #%0d: got j=%0d want j=%0d", p, pulses[p], 7 + 101 * p);
        end
      end
    end
    n_checks++;
    if (rejects != 1 || max_pend != 4 || !saw_full) begin
      n_fail++;
      $display("FAIL queue_overflow: rejects=%0d max_pend=%0d full=%0d want 1 4 1",
               rejects, max_pend, saw_full);
    end
  endtask

  task automatic test_reset_mid_gap();
    for (int j = 0; j < 300; j++) begin
      nk[1] = (j < 36) && ((j % 12) < 6);
      rst_n = (j != 40);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ({coin_o[i], rej_o[i], full_o[i], pend_o[i]} !== exp_o[i]) begin
          n_fail++;
          $display("FAIL midreset_model inst%0d j=%0d: got %b want %b", i, j,
                   {coin_o[i], rej_o[i], full_o[i], pend_o[i]}, exp_o[i]);
        end
      end
      if (j == 39) begin
        n_checks++;
        if (pend_o[1] !== 3'd2) begin
          n_fail++;
          $display("FAIL midreset_pre: pending %0d want 2", pend_o[1]);
        end
      end
      if (j == 40) begin
        n_checks++;
        if ({coin_o[1], full_o[1], pend_o[1]} !== 6'b0) begin
          n_fail++;
          $display("FAIL midreset_clear: coin=%b full=%b pend=%0d want 0", coin_o[1], full_o[1], pend_o[1]);
        end
      end
      if (j > 40) begin
        n_checks++;
        if (coin_o[1] !== 2'b00) begin
          n_fail++;
          $display("FAIL midreset_no_emit j=%0d: coin %b want 00", j, coin_o[1]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int hold [2][2];
    for (int i = 0; i < 2; i++) begin hold[i][0] = 0; hold[i][1] = 0; end
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i][0] == 0) begin nk[i] = 1'($urandom_range(0, 1)); hold[i][0] = $urandom_range(1, 10); end
        if (hold[i][1] == 0) begin dm[i] = 1'($urandom_range(0, 1)); hold[i][1] = $urandom_range(1, 10); end
        hold[i][0]--; hold[i][1]--;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if ({coin_o[i], rej_o[i], full_o[i], pend_o[i]} !== exp_o[i]) begin
          n_fail++;
          $display("FAIL random inst%0d j=%0d: got %b want %b", i, j,
                   {coin_o[i], rej_o[i], full_o[i], pend_o[i]}, exp_o[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin nk[i] = 1'b0; dm[i] = 1'b0; end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) begin nk[i] = 1'b0; dm[i] = 1'b0; end
    test_reset();
    test_single_coin(1'b0);
    test_single_coin(1'b1);
    test_short_pulse();
    test_simultaneous();
    test_queue_full();
    test_reset_mid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
